// File: rtl/mem_boot_loader_pkg.sv
// Shared constants and FSM encoding for the boot-time memory loader.
package mem_boot_loader_pkg;

    localparam logic [7:0] CMD_WR_IMEM = 8'hA0;
    localparam logic [7:0] CMD_WR_DMEM = 8'hA1;
    localparam logic [7:0] CMD_GO      = 8'hA5;

    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ADDR0 = 4'd1,
        ST_ADDR1 = 4'd2,
        ST_LEN0  = 4'd3,
        ST_LEN1  = 4'd4,
        ST_DATA  = 4'd5,
        ST_CSUM  = 4'd6,
        ST_RUN   = 4'd7,
        ST_ERROR = 4'd8
    } state_t;

endpackage

// File: rtl/mem_boot_loader.sv
// Byte-stream loader: writes packets into IMEM/DMEM, holds the CPU in reset until GO.
// Latency: payload byte accepted in cycle N is written in N+1; in_ready drops in RUN/ERROR.
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] MEM_BYTES = 17'(1 << ADDR_W);

    state_t              state;
    logic [15:0]         addr;
    logic [7:0]          len_lo;
    logic [15:0]         remaining;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [7:0]          csum;

    logic                xfer;
    logic [15:0]         len_full;
    logic [16:0]         end_addr;

    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, len_lo};
    // Range check uses the full 16-bit address so out-of-window bases are caught.
    assign end_addr = {1'b0, addr} + {1'b0, len_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= SEL_IMEM;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            addr      <= '0;
            len_lo    <= '0;
            remaining <= '0;
            wr_ptr    <= '0;
            csum      <= '0;
        end else begin
            mem_we   <= 1'b0;
            in_ready <= (state != ST_RUN) && (state != ST_ERROR);
            if (xfer) begin
                case (state)
                    ST_IDLE: begin
                        csum <= '0;
                        if (in_data == CMD_WR_IMEM || in_data == CMD_WR_DMEM) begin
                            mem_sel <= (in_data == CMD_WR_DMEM) ? SEL_DMEM : SEL_IMEM;
                            state   <= ST_ADDR0;
                        end else if (in_data == CMD_GO && !err) begin
                            state    <= ST_RUN;
                            in_ready <= 1'b0;
                            cpu_rst  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= ST_ERROR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end
                    end
                    ST_ADDR0: begin
                        addr[7:0] <= in_data;
                        state     <= ST_ADDR1;
                    end
                    ST_ADDR1: begin
                        addr[15:8] <= in_data;
                        state      <= ST_LEN0;
                    end
                    ST_LEN0: begin
                        len_lo <= in_data;
                        state  <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        if (end_addr > MEM_BYTES) begin
                            state    <= ST_ERROR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            wr_ptr    <= ADDR_W'(addr);
                            remaining <= len_full;
                            state     <= (len_full == 16'd0) ? ST_CSUM : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= in_data;
                        wr_ptr    <= wr_ptr + 1'b1;
                        csum      <= csum + in_data;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        if (in_data == csum) begin
                            state <= ST_IDLE;
                            csum  <= '0;
                        end else begin
                            state    <= ST_ERROR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
